// File: rtl/rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_bus_ctrl
//
// Runs one multiplexed address/data register access on the external RTC chip's
// AD bus for each accepted request. A request is taken only in IDLE. The
// address, write data and direction are latched on the request edge. The cycle
// then steps through a fixed state sequence:
//   A_SETUP -> A_STROBE -> A_HOLD -> D_SETUP -> D_STROBE -> D_HOLD -> RECOVER
// The duration of each state is set by a parameter.
//
// Parameters (cycles, each 1..255):
//   T_SETUP  address/data setup before a strobe falls
//   T_PULSE  strobe low time
//   T_HOLD   address/data hold after a strobe rises
//   T_GAP    cs_n-high recovery between transactions
//
// Ports:
//   clk       system clock, rising edge
//   Reset_n   asynchronous active-low reset
//   wr_req    one-cycle pulse, write data_wr to address
//   rd_req    one-cycle pulse, read address (a simultaneous wr_req wins)
//   address   RTC register address
//   data_wr   write data (BCD)
//   ad_in     AD bus input from pad
//   ad_out    AD bus output to pad
//   ad_oe     AD pad output enable, 1 = drive
//   cs_n      chip select, active low
//   rd_n      read strobe, active low
//   wr_n      write strobe, active low
//   a_d       0 = address phase, 1 = data phase
//   data_rd   last read byte, updated only by a completed read
//   busy      transaction in progress
//   done      one-cycle pulse when a transaction finishes
//   err       one-cycle pulse on a rejected write
//
// Build option:
//   RTC_BCD_CHECK_EN  If defined, a write whose data has a nibble above 9 is
//                     rejected. No bus cycle runs, and err pulses on the
//                     following cycle. If undefined, err is tied low and all
//                     writes run.
// -----------------------------------------------------------------------------
module rtc_bus_ctrl #(
  parameter int T_SETUP = 4,
  parameter int T_PULSE = 10,
  parameter int T_HOLD  = 4,
  parameter int T_GAP   = 8
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] address,
  input  logic [7:0] data_wr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_A_SETUP  = 3'd1;
  localparam logic [2:0] S_A_STROBE = 3'd2;
  localparam logic [2:0] S_A_HOLD   = 3'd3;
  localparam logic [2:0] S_D_SETUP  = 3'd4;
  localparam logic [2:0] S_D_STROBE = 3'd5;
  localparam logic [2:0] S_D_HOLD   = 3'd6;
  localparam logic [2:0] S_RECOVER  = 3'd7;

  // Counter reload values. A state lasts N cycles, so the counter loads N-1.
  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       cap;

  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       is_rd_q;
  logic [7:0] addr_nx;
  logic [7:0] data_nx;
  logic       dir_nx;

  logic       cs_d;
  logic       rd_d;
  logic       wr_d;
  logic       ad_d;
  logic       oe_d;
  logic [7:0] out_d;

  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      S_A_SETUP:  succ = S_A_STROBE;
      S_A_STROBE: succ = S_A_HOLD;
      S_A_HOLD:   succ = S_D_SETUP;
      S_D_SETUP:  succ = S_D_STROBE;
      S_D_STROBE: succ = S_D_HOLD;
      S_D_HOLD:   succ = S_RECOVER;
      default:    succ = S_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] load(input logic [2:0] s);
    case (s)
      S_A_SETUP, S_D_SETUP:   load = LD_SETUP;
      S_A_STROBE, S_D_STROBE: load = LD_PULSE;
      S_A_HOLD, S_D_HOLD:     load = LD_HOLD;
      S_RECOVER:              load = LD_GAP;
      default:                load = 8'd0;
    endcase
  endfunction

`ifdef RTC_BCD_CHECK_EN
  logic rej;

  function automatic logic bcd_ok(input logic [7:0] d);
    bcd_ok = (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction
`endif

  // Next-state and counter. Requests are looked at only in IDLE, so anything
  // that arrives while a cycle is running is dropped.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    rej      = 1'b0;
`endif
    if (state == S_IDLE) begin
      if (wr_req) begin
`ifdef RTC_BCD_CHECK_EN
        if (bcd_ok(data_wr)) cap = 1'b1;
        else                 rej = 1'b1;
`else
        cap = 1'b1;
`endif
      end else if (rd_req) begin
        cap = 1'b1;
      end
      if (cap) begin
        state_nx = S_A_SETUP;
        cnt_nx   = LD_SETUP;
      end
    end else if (cnt != 8'd0) begin
      cnt_nx = cnt - 8'd1;
    end else begin
      state_nx = succ(state);
      cnt_nx   = load(state_nx);
    end
  end

  // The latched values that take effect with the next state. This lets the
  // pad registers show the new address in the first A_SETUP cycle.
  always_comb begin
    addr_nx = cap ? address  : addr_q;
    data_nx = cap ? data_wr  : data_q;
    dir_nx  = cap ? !wr_req  : is_rd_q;
  end

  // Decode the pad levels for the next state. Registering the result gives
  // glitch-free strobes on the same cycle boundaries as the state itself. The
  // read strobe and the pad driver are never active in the same state.
  always_comb begin
    cs_d  = 1'b1;
    rd_d  = 1'b1;
    wr_d  = 1'b1;
    ad_d  = 1'b1;
    oe_d  = 1'b0;
    out_d = 8'h00;
    case (state_nx)
      S_A_SETUP, S_A_HOLD: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_nx;
      end
      S_A_STROBE: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_nx;
        wr_d  = 1'b0;
      end
      S_D_SETUP, S_D_HOLD: begin
        cs_d = 1'b0;
        if (!dir_nx) begin
          oe_d  = 1'b1;
          out_d = data_nx;
        end
      end
      S_D_STROBE: begin
        cs_d = 1'b0;
        if (dir_nx) begin
          rd_d = 1'b0;
        end else begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = data_nx;
        end
      end
      default: ;
    endcase
  end

  // Request latches. These registers are plain data and are only read while
  // a cycle is running.
  always_ff @(posedge clk) begin
    if (cap) begin
      addr_q  <= address;
      data_q  <= data_wr;
      is_rd_q <= !wr_req;
    end
  end

  // Control state and registered pad outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      data_rd <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      cs_n   <= cs_d;
      rd_n   <= rd_d;
      wr_n   <= wr_d;
      a_d    <= ad_d;
      ad_oe  <= oe_d;
      ad_out <= out_d;
      busy   <= (state_nx != S_IDLE);
      done   <= (state != S_IDLE) && (state_nx == S_IDLE);
      // Sample the pad on the last cycle that rd_n is low.
      if ((state == S_D_STROBE) && (cnt == 8'd0) && is_rd_q) begin
        data_rd <= ad_in;
      end
    end
  end

`ifdef RTC_BCD_CHECK_EN
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) err <= 1'b0;
    else          err <= rej;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_ctrl
//
// Bench for rtc_bus_ctrl with its default timing. The reference model tracks
// each transaction as a cycle index counted from capture. It derives every
// expected pad level from the phase windows of that index. It also tracks the
// last read byte and the done and err pulses.
// -----------------------------------------------------------------------------
module tb_rtc_bus_ctrl;

  localparam int S   = 4;
  localparam int P   = 10;
  localparam int H   = 4;
  localparam int G   = 8;
  localparam int B   = S + P + H;
  localparam int TOT = 2 * B + G;

  logic       clk;
  logic       Reset_n;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] address;
  logic [7:0] data_wr;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] data_rd;
  logic       busy;
  logic       done;
  logic       err;

  rtc_bus_ctrl #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G)) dut (
    .clk(clk), .Reset_n(Reset_n), .wr_req(wr_req), .rd_req(rd_req),
    .address(address), .data_wr(data_wr), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .data_rd(data_rd), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit         m_act;
  int         m_t;
  bit         m_rd;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_data_rd;
  bit         m_done;
  bit         m_err;
  logic [7:0] rd_val;

  int checks;
  int errors;

`ifdef RTC_BCD_CHECK_EN
  function automatic bit bcd_bad(input logic [7:0] d);
    return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
  endfunction
`endif

  function automatic logic [23:0] obs_vec();
    return {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, err, data_rd,
            (ad_oe ? ad_out : 8'h00)};
  endfunction

  function automatic logic [23:0] exp_vec();
    bit in_a, in_bus, astb, dstb, oe;
    logic [7:0] o;
    in_a   = m_act && (m_t < B);
    in_bus = m_act && (m_t < 2 * B);
    astb   = m_act && (m_t >= S) && (m_t < S + P);
    dstb   = m_act && (m_t >= B + S) && (m_t < B + S + P);
    oe     = in_a || (in_bus && !m_rd);
    o      = !oe ? 8'h00 : (in_a ? m_addr : m_data);
    return {!in_bus, !(dstb && m_rd), !(astb || (dstb && !m_rd)), !in_a, oe,
            m_act, m_done, m_err, m_data_rd, o};
  endfunction

  // Advance one clock: the model consumes the inputs present before the edge.
  // Request pulses are then cleared and ad_in is refreshed.
  task automatic tick();
    logic w, r;
    logic [7:0] a, d, ai;
    bit ok;
    w = wr_req; r = rd_req; a = address; d = data_wr; ai = ad_in;
    @(posedge clk);
    m_done = 0;
    m_err  = 0;
    if (m_act) begin
      m_t++;
      if (m_rd && (m_t == B + S + P)) m_data_rd = ai;
      if (m_t == TOT) begin
        m_act  = 0;
        m_done = 1;
      end
    end else if (w) begin
      ok = 1;
`ifdef RTC_BCD_CHECK_EN
      ok    = !bcd_bad(d);
      m_err = !ok;
`endif
      if (ok) begin
        m_act = 1; m_t = 0; m_rd = 0; m_addr = a; m_data = d;
      end
    end else if (r) begin
      m_act = 1; m_t = 0; m_rd = 1; m_addr = a;
    end
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    ad_in  = (m_act && m_rd && (m_t >= B + S) && (m_t < B + S + P)) ? rd_val
                                                                    : 8'($urandom);
  endtask

  task automatic model_reset();
    m_act = 0; m_t = 0; m_rd = 0; m_done = 0; m_err = 0; m_data_rd = 8'h00;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, err, data_rd, ad_out} !== 24'hF0_00_00) begin
      errors++;
      $display("FAIL reset_idle: got %h exp %h",
               {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, err, data_rd, ad_out}, 24'hF0_00_00);
    end
    Reset_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_write();
    int wr_low = 0;
    int done_at = -1;
    address = 8'h21; data_wr = 8'h45; wr_req = 1'b1;
    for (int j = 0; j <= TOT + 2; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL write cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (!wr_n) wr_low++;
      if (done && done_at < 0) done_at = j;
    end
    checks++;
    if (done_at != 44) begin
      errors++;
      $display("FAIL write_latency: got %0d exp 44", done_at);
    end
    checks++;
    if (wr_low != 20) begin
      errors++;
      $display("FAIL write_wr_low: got %0d exp 20", wr_low);
    end
  endtask

  task automatic test_read();
    int rd_low = 0;
    int wr_data = 0;
    int oe_rd = 0;
    address = 8'h23; rd_val = 8'h12; rd_req = 1'b1;
    for (int j = 0; j <= TOT + 2; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL read cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (!rd_n) rd_low++;
      if (!wr_n && a_d) wr_data++;
      if (ad_oe && !rd_n) oe_rd++;
    end
    checks++;
    if (data_rd !== 8'h12) begin
      errors++;
      $display("FAIL read_data: got %h exp 12", data_rd);
    end
    checks++;
    if (rd_low != 10 || wr_data != 0 || oe_rd != 0) begin
      errors++;
      $display("FAIL read_strobes: rd_low %0d wr_data %0d oe_rd %0d exp 10 0 0",
               rd_low, wr_data, oe_rd);
    end
  endtask

  task automatic test_collisions();
    int rd_low = 0;
    int dones = 0;
    address = 8'h24; data_wr = 8'h31; wr_req = 1'b1; rd_req = 1'b1;
    for (int j = 0; j <= TOT + 2; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collide_both cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (!rd_n) rd_low++;
    end
    checks++;
    if (rd_low != 0) begin
      errors++;
      $display("FAIL collide_rd_low: got %0d exp 0", rd_low);
    end
    address = 8'h22; data_wr = 8'h12; wr_req = 1'b1;
    for (int j = 0; j <= TOT + 3; j++) begin
      if (j == 20) begin
        wr_req = 1'b1; address = 8'h25; data_wr = 8'h99;
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collide_busy cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL collide_dones: got %0d exp 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    bit issued = 0;
    bit prev_cs = 1;
    int hi = 0;
    int falls = 0;
    int gap = -1;
    address = 8'h21; data_wr = 8'h59; wr_req = 1'b1;
    for (int j = 0; j < 2 * TOT + 10; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (!cs_n && prev_cs) begin
        falls++;
        if (falls == 2) gap = hi;
      end
      if (cs_n) hi++;
      else      hi = 0;
      prev_cs = cs_n;
      if (done && !issued) begin
        issued = 1; wr_req = 1'b1; address = 8'h22; data_wr = 8'h07;
      end
    end
    checks++;
    if (!issued || falls != 2 || gap < G) begin
      errors++;
      $display("FAIL b2b_gap: issued %0d falls %0d gap %0d exp 1 2 >=%0d",
               issued, falls, gap, G);
    end
  endtask

  task automatic test_reset_mid();
    address = 8'h23; data_wr = 8'h11; wr_req = 1'b1;
    for (int j = 0; j < S + 4; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_pre cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (wr_n !== 1'b0 || a_d !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_strobe: wr_n %b a_d %b exp 0 0", wr_n, a_d);
    end
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, err, data_rd, ad_out} !== 24'hF0_00_00) begin
      errors++;
      $display("FAIL rstmid_async: got %h exp %h",
               {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, err, data_rd, ad_out}, 24'hF0_00_00);
    end
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_after cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bcd();
    int dones = 0;
    int errs = 0;
    int cs_low = 0;
    int data_seen = 0;
    address = 8'h22; data_wr = 8'h5A; wr_req = 1'b1;
    for (int j = 0; j <= TOT + 3; j++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bcd cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      if (done) dones++;
      if (err) errs++;
      if (!cs_n) cs_low++;
      if (ad_oe && a_d && ad_out == 8'h5A) data_seen++;
    end
    checks++;
`ifdef RTC_BCD_CHECK_EN
    if (errs != 1 || dones != 0 || cs_low != 0) begin
      errors++;
      $display("FAIL bcd_reject: err %0d done %0d cs_low %0d exp 1 0 0", errs, dones, cs_low);
    end
`else
    if (errs != 0 || dones != 1 || data_seen != S + P + H) begin
      errors++;
      $display("FAIL bcd_pass: err %0d done %0d data_cycles %0d exp 0 1 %0d",
               errs, dones, data_seen, S + P + H);
    end
`endif
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      wr_req  = ($urandom_range(0, 5) == 0);
      rd_req  = ($urandom_range(0, 5) == 0);
      address = 8'($urandom);
      data_wr = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                            : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rd_val  = 8'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h exp %h", j, obs_vec(), exp_vec());
      end
      checks++;
      if ((!rd_n && !wr_n) || (ad_oe && !rd_n)) begin
        errors++;
        $display("FAIL random_strobe_rule cyc %0d: rd_n %b wr_n %b ad_oe %b exp no overlap",
                 j, rd_n, wr_n, ad_oe);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    address = 8'h00; data_wr = 8'h00; ad_in = 8'h00; rd_val = 8'h00;
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_collisions();
    test_back_to_back();
    test_reset_mid();
    test_bcd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
